// File: rtl/uart_word_tx.sv
// uart_word_tx: UART 8N1 transmitter for 16-bit words.
// Words enter through a valid/ready handshake into a small FIFO and leave
// on the serial line as two back-to-back frames, low byte first.

module uart_word_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int WORD_WIDTH   = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk_50M,
  input  logic                          rst,
  input  logic [WORD_WIDTH-1:0]         word_in,
  input  logic                          word_valid,
  output logic                          word_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                stateQ;
  logic [BAUD_W-1:0]     baudQ;
  logic [2:0]            bitIdxQ;
  logic                  byteSelQ;
  logic [WORD_WIDTH-1:0] shiftQ;
  logic                  txQ;

  logic [WORD_WIDTH-1:0] memQ [FIFO_DEPTH];
  logic [PTR_W-1:0]      headQ;
  logic [PTR_W-1:0]      tailQ;
  logic [CNT_W-1:0]      countQ;
  logic [CNT_W-1:0]      countD;

  logic                  pushEn;
  logic                  popEn;
  logic                  bitDone;

  // The FIFO takes a word whenever it has room; a full FIFO simply ignores
  // word_valid, even if a pop frees a slot on the same edge.
  assign word_ready = (countQ != CNT_FULL);
  assign pushEn     = word_valid & word_ready;
  assign bitDone    = (baudQ == BAUD_LAST);

  // A word leaves the FIFO either from IDLE, or at the very last cycle of the
  // high-byte stop bit so the next word's start bit follows with no gap.
  assign popEn = (countQ != '0) &
                 ((stateQ == IDLE) | ((stateQ == STOP) & bitDone & byteSelQ));

  assign busy       = (stateQ != IDLE) | (countQ != '0);
  assign fifo_count = countQ;
  assign tx         = txQ;

  // Occupancy bookkeeping: a simultaneous push and pop leaves the count alone.
  always_comb begin
    countD = countQ;
    case ({pushEn, popEn})
      2'b10:   countD = countQ + CNT_W'(1);
      2'b01:   countD = countQ - CNT_W'(1);
      default: countD = countQ;
    endcase
  end

  // Head/tail pointers and count; reset flushes the FIFO by clearing these.
  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst) begin
      headQ  <= '0;
      tailQ  <= '0;
      countQ <= '0;
    end else begin
      if (pushEn) begin
        tailQ <= tailQ + PTR_W'(1);
      end
      if (popEn) begin
        headQ <= headQ + PTR_W'(1);
      end
      countQ <= countD;
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_50M) begin
    if (pushEn) begin
      memQ[tailQ] <= word_in;
    end
  end

  // Serializer FSM. The popped word is copied into a shift register that moves
  // one place per data bit, so after the low byte the high byte sits at the
  // bottom. tx is registered and updated on the same edge as each state entry.
  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst) begin
      stateQ   <= IDLE;
      baudQ    <= '0;
      bitIdxQ  <= '0;
      byteSelQ <= 1'b0;
      shiftQ   <= '0;
      txQ      <= 1'b1;
    end else begin
      case (stateQ)
        IDLE: begin
          txQ   <= 1'b1;
          baudQ <= '0;
          if (popEn) begin
            shiftQ   <= memQ[headQ];
            byteSelQ <= 1'b0;
            stateQ   <= START;
            txQ      <= 1'b0;
          end
        end

        START: begin
          if (bitDone) begin
            baudQ   <= '0;
            bitIdxQ <= '0;
            stateQ  <= DATA;
            txQ     <= shiftQ[0];
          end else begin
            baudQ <= baudQ + BAUD_W'(1);
          end
        end

        DATA: begin
          if (bitDone) begin
            baudQ  <= '0;
            shiftQ <= shiftQ >> 1;
            if (bitIdxQ == 3'd7) begin
              stateQ <= STOP;
              txQ    <= 1'b1;
            end else begin
              bitIdxQ <= bitIdxQ + 3'd1;
              txQ     <= shiftQ[1];
            end
          end else begin
            baudQ <= baudQ + BAUD_W'(1);
          end
        end

        STOP: begin
          if (bitDone) begin
            baudQ <= '0;
            if (!byteSelQ) begin
              byteSelQ <= 1'b1;
              stateQ   <= START;
              txQ      <= 1'b0;
            end else if (popEn) begin
              shiftQ   <= memQ[headQ];
              byteSelQ <= 1'b0;
              stateQ   <= START;
              txQ      <= 1'b0;
            end else begin
              stateQ <= IDLE;
              txQ    <= 1'b1;
            end
          end else begin
            baudQ <= baudQ + BAUD_W'(1);
          end
        end

        default: begin
          stateQ <= IDLE;
          baudQ  <= '0;
          txQ    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: self-checking bench for uart_word_tx.
// A cycle-level reference model predicts the serial waveform and FIFO state
// from the word-level rules: words queue up, each started word produces a
// 20-bit (two-frame) line pattern, and a new word starts when the line is free.

module tb_uart_word_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 20 * CPB;

  logic        clk_50M;
  logic        rst;
  logic [15:0] wordIn;
  logic        wordValid;
  logic        wordReady;
  logic        tx;
  logic        busy;
  logic [2:0]  fifoCount;

  int checksDone;
  int checksPassed;

  logic [15:0] modelFifo [$];
  bit          txExp [$];
  int          frameLeft;
  int          popCount;

  logic [15:0] burst [6];

  uart_word_tx #(
    .CLKS_PER_BIT (CPB),
    .WORD_WIDTH   (16),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_50M    (clk_50M),
    .rst        (rst),
    .word_in    (wordIn),
    .word_valid (wordValid),
    .word_ready (wordReady),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifoCount)
  );

  // 100 MHz-style sim clock; only the cycle count matters.
  initial clk_50M = 1'b0;
  always #5 clk_50M = ~clk_50M;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checksDone++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t",
               tag, observed, expected, $time);
    end else begin
      checksPassed++;
    end
  endtask

  task automatic modelReset();
    modelFifo.delete();
    txExp.delete();
    frameLeft = 0;
  endtask

  // Append the line levels for one word: two 8N1 frames, low byte first.
  task automatic queueFrame(input logic [15:0] w);
    logic [7:0] thisByte;
    bit         lvl;
    for (int b = 0; b < 2; b++) begin
      thisByte = (b == 0) ? w[7:0] : w[15:8];
      for (int s = 0; s < 10; s++) begin
        if (s == 0)      lvl = 1'b0;
        else if (s == 9) lvl = 1'b1;
        else             lvl = thisByte[s-1];
        repeat (CPB) txExp.push_back(lvl);
      end
    end
  endtask

  // One clock edge of the word-level model, using pre-edge state and inputs.
  task automatic modelEdge();
    int  sz;
    bit  popNow;
    bit  accept;
    sz     = modelFifo.size();
    popNow = (sz > 0) && (frameLeft <= 1);
    accept = wordValid && (sz < DEPTH);
    if (popNow) begin
      queueFrame(modelFifo.pop_front());
      frameLeft = FRAME;
      popCount++;
    end else if (frameLeft > 0) begin
      frameLeft--;
    end
    if (accept) modelFifo.push_back(wordIn);
  endtask

  // Advance one edge, update the model, then compare all outputs 1 ns later.
  task automatic tick();
    bit expTx;
    @(posedge clk_50M);
    if (!rst) modelReset();
    else      modelEdge();
    #1;
    expTx = (txExp.size() > 0) ? txExp.pop_front() : 1'b1;
    checkOutput("tx", 32'(tx), 32'(expTx));
    checkOutput("busy", 32'(busy),
                32'((frameLeft > 0) || (modelFifo.size() > 0)));
    checkOutput("fifo_count", 32'(fifoCount), 32'(modelFifo.size()));
    checkOutput("word_ready", 32'(wordReady), 32'(modelFifo.size() < DEPTH));
  endtask

  task automatic applyStimulus(input bit v, input logic [15:0] w);
    wordValid = v;
    wordIn    = w;
    tick();
    wordValid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'($urandom()));
  endtask

  task automatic drain();
    for (int i = 0; i < (DEPTH + 2) * FRAME + 10; i++) begin
      if (modelFifo.size() == 0 && frameLeft == 0) break;
      applyStimulus(1'b0, 16'($urandom()));
    end
    checkOutput("drain_busy", 32'(busy), 32'd0);
  endtask

  task automatic waitStart(input string tag);
    for (int i = 0; i < 10 && tx !== 1'b0; i++) applyStimulus(1'b0, 16'($urandom()));
    checkOutput(tag, 32'(tx), 32'd0);
  endtask

  initial begin
    logic [19:0] t2Pattern;
    int          thr;
    checksDone   = 0;
    checksPassed = 0;
    popCount     = 0;
    wordValid    = 1'b0;
    wordIn       = 16'h0000;
    modelReset();

    // Test 1: reset state, then idle with no pushes.
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    checkOutput("reset_tx", 32'(tx), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_ready", 32'(wordReady), 32'd1);
    checkOutput("reset_count", 32'(fifoCount), 32'd0);
    repeat (3) tick();
    #2 rst = 1'b1;
    idleCycles(10);
    checkOutput("idle_tx", 32'(tx), 32'd1);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    // Test 2: single word 0x12A5, exact line pattern and busy fall.
    $display("[TB] single word 0x12A5");
    t2Pattern = 20'b0101001011_0010010001;
    applyStimulus(1'b1, 16'h12A5);
    checkOutput("t2_no_start_yet", 32'(tx), 32'd1);
    tick();
    checkOutput("t2_latency", 32'(tx), 32'd0);
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) tick();
      checkOutput("t2_bit", 32'(tx), 32'(t2Pattern[19 - i / CPB]));
      checkOutput("t2_busy", 32'(busy), 32'd1);
    end
    tick();
    checkOutput("t2_busy_fall", 32'(busy), 32'd0);
    idleCycles(5);

    // Test 3: six pushes on consecutive edges; the sixth is refused.
    $display("[TB] six-word burst");
    for (int k = 0; k < 6; k++) burst[k] = 16'($urandom());
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, burst[k]);
      if (k == 4) begin
        checkOutput("t3_full_count", 32'(fifoCount), 32'd4);
        checkOutput("t3_full_ready", 32'(wordReady), 32'd0);
      end
    end
    checkOutput("t3_after6_count", 32'(fifoCount), 32'd4);
    drain();
    idleCycles(3);

    // Test 4: two queued words go out back to back.
    $display("[TB] back-to-back words");
    applyStimulus(1'b1, 16'($urandom()));
    applyStimulus(1'b1, 16'($urandom()));
    waitStart("t4_start_seen");
    for (int i = 0; i < FRAME - 1; i++) tick();
    checkOutput("t4_stop_hi", 32'(tx), 32'd1);
    tick();
    checkOutput("t4_b2b_start", 32'(tx), 32'd0);
    drain();
    idleCycles(3);

    // Test 5: asynchronous reset during DATA bit 3 of the second word.
    $display("[TB] async reset mid-frame");
    popCount = 0;
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 16'($urandom()));
    for (int i = 0; i < 3 * FRAME && !(popCount == 2 && frameLeft == FRAME - 17); i++)
      applyStimulus(1'b0, 16'($urandom()));
    checkOutput("t5_pre_count", 32'(fifoCount), 32'd2);
    #2 rst = 1'b0;
    #1;
    modelReset();
    checkOutput("t5_rst_tx", 32'(tx), 32'd1);
    checkOutput("t5_rst_count", 32'(fifoCount), 32'd0);
    checkOutput("t5_rst_busy", 32'(busy), 32'd0);
    checkOutput("t5_rst_ready", 32'(wordReady), 32'd1);
    repeat (2) tick();
    #2 rst = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      applyStimulus(1'b0, 16'($urandom()));
      checkOutput("t5_line_high", 32'(tx), 32'd1);
    end

    // Test 6: push on the same edge as a due pop with two words waiting.
    $display("[TB] push coincident with pop");
    popCount = 0;
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 16'($urandom()));
    for (int i = 0; i < 2 * FRAME && !(popCount == 1 && frameLeft == 1); i++)
      applyStimulus(1'b0, 16'($urandom()));
    checkOutput("t6_pre_count", 32'(fifoCount), 32'd2);
    applyStimulus(1'b1, 16'($urandom()));
    checkOutput("t6_count_hold", 32'(fifoCount), 32'd2);
    drain();
    idleCycles(3);

    // Randomized traffic with varying push density.
    $display("[TB] random traffic");
    thr = 10;
    for (int i = 0; i < 2400; i++) begin
      if (i % 200 == 0) thr = int'($urandom_range(0, 60));
      applyStimulus($urandom_range(0, 99) < thr, 16'($urandom()));
    end
    drain();

    $display("%0d/%0d checks passed", checksPassed, checksDone);
    $finish;
  end

endmodule
